if_fetch_unit: RTL and testbench
================================

Name: if_fetch_unit

Overview:
- Instruction-fetch stage, directly upstream of the IF/ID pipeline register.
- Generates the sequential PC and issues requests to instruction memory over a valid/ready request channel with in-order responses of variable latency.
- Buffers returned instructions in a small FIFO and presents pc/instr/valid to IF/ID, honouring stall.
- On a branch redirect, flushes buffered and in-flight fetches.

Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- DEPTH, 2, output FIFO entries; also the credit limit on outstanding plus buffered fetches (min 1, max 8).

Ports:
- clk  input  1  clock, rising edge.
- rst_  input  1  synchronous, active-high reset.
- stall  input  1  hazard unit holds the IF/ID register; do not pop.
- branch  input  1  redirect request from EX, single-cycle pulse.
- branch_target  input  32  redirect address; bits [1:0] forced to 0 internally.
- imem_req_valid  output  1  fetch request valid.
- imem_req_ready  input  1  memory accepts request.
- imem_addr  output  32  fetch address, word aligned.
- imem_rsp_valid  input  1  response valid; in order; latency ≥1 cycle after acceptance.
- imem_rsp_data  input  32  fetched instruction.
- pc  output  32  PC of head instruction, to IF/ID pc.
- instr  output  32  head instruction, to IF/ID instr.
- valid  output  1  head entry valid, to IF/ID valid.

Behaviour:
- State: BOOT, RUN. Reset enters BOOT. BOOT→RUN after exactly 1 cycle. No requests are issued in BOOT, and responses in BOOT are ignored.
- Registers:
  - fetch_pc: next address to request.
  - resp_pc: PC of the next expected response.
  - outst: requests accepted but not yet responded, 0..DEPTH.
  - drop_cnt: responses still to discard.
  - FIFO: count, rd/wr pointers.
- Reset values: fetch_pc = resp_pc = RESET_PC; outst = drop_cnt = 0; FIFO empty; imem_req_valid = 0; valid = 0; pc = RESET_PC; instr = 32'h0000_0013 (NOP).
- imem_req_valid = RUN & !branch & (outst + count < DEPTH). imem_addr = fetch_pc.
- Issue fire = req_valid & req_ready. On fire: fetch_pc += 4 (wraps modulo 2^32); outst + 1.
- Response fire, any cycle imem_rsp_valid:
  - outst − 1.
  - If drop_cnt > 0: discard, drop_cnt − 1.
  - Else: push {resp_pc, rsp_data}, resp_pc += 4.
- Output: valid = (count ≠ 0); pc/instr = FIFO head, combinational from the storage registers. When count = 0, pc/instr hold the last popped values (RESET_PC/NOP after reset).
- Pop when valid & !stall & !branch. Push and pop in the same cycle leave count unchanged. Pushing into an empty FIFO makes the entry visible the next cycle; there is no bypass, so fetch-to-valid latency is imem latency + 1.
- Branch, highest priority after reset:
  - FIFO cleared, no pop, no push.
  - fetch_pc = resp_pc = {branch_target[31:2], 2'b00}.
  - drop_cnt = outst − rsp_fire (all still in flight).
  - No request is issued in the branch cycle. The target is requested no earlier than the next cycle.
- Stall only blocks pops. Issue continues until the credit limit, so the FIFO fills to DEPTH and then req_valid = 0.
- Branch with stall in the same cycle: redirect wins and the FIFO is flushed.
- Credit rule guarantees no FIFO overflow. A response arriving with outst = 0 is a protocol error: assertion, ignored.
- Reset mid-operation: all state returns to reset values in one cycle, independent of other inputs. imem shares the reset, so no stale responses return.

Decomposition:
- Shared package rv32_pkg: XLEN = 32, NOP_INSTR = 32'h0000_0013, PC_INCR = 4.
- One sub-module, fetch_fifo: synchronous FIFO, parameter DEPTH, 64-bit entries {pc, instr}, ports push/pop/clear/count/head. It is reusable for later buffering stages.
- Credit logic, FSM and drop counter stay in the top level.

Test Plan:
- Reset, then imem ready = 1 with 1-cycle latency → requests 0x0, 0x4, 0x8…. First valid = 1 at cycle 3 after reset deassertion, with pc = 0x0 and instr = memory[0]. Then one instruction per cycle with consecutive PCs.
- Stall held 5 cycles during streaming → pc/instr frozen. At most 2 requests are issued (DEPTH = 2), then imem_req_valid = 0. After release, order continues with no skip or duplicate.
- Branch to 0x0000_0102 with 2 requests in flight (latency 2) → both responses discarded. Next request address = 0x0000_0100. First valid output has pc = 0x100.
- Branch asserted together with stall while the FIFO is full → valid = 0 next cycle, FIFO empty, fetch resumes at the target.
- Random imem_req_ready back-pressure (50%) and latency 1–3 over 200 fetches → output PCs strictly +4 sequential, never more than DEPTH outstanding plus buffered, no overflow assertion.
- rst_ pulsed mid-stream with the FIFO holding 2 entries → next cycle valid = 0, pc = RESET_PC, instr = 0x00000013. First request is 1 cycle after BOOT, at RESET_PC.

Source files
------------

// File: rtl/rv32_pkg.sv
// Shared RV32 constants and fetch-path types used by the instruction-fetch stage.
package rv32_pkg;

  localparam int          XLEN      = 32;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  localparam logic [31:0] PC_INCR   = 32'd4;

  typedef enum logic {
    ST_BOOT = 1'b0,
    ST_RUN  = 1'b1
  } fetch_state_e;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO with a synchronous clear; when empty, head shows the
// most recently popped entry (IDLE_HEAD after reset).
module fetch_fifo #(
  parameter int          DEPTH     = 2,
  parameter int          W         = 64,
  parameter logic [W-1:0] IDLE_HEAD = '0,
  localparam int         CW        = $clog2(DEPTH + 1),
  localparam int         PW        = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          rst_,
  input  logic          push,
  input  logic [W-1:0]  push_data,
  input  logic          pop,
  input  logic          clear,
  output logic [CW-1:0] count,
  output logic [W-1:0]  head
);

  logic [W-1:0]  mem_q [DEPTH];
  logic [W-1:0]  mem_d [DEPTH];
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [W-1:0]  last_q, last_d;
  logic          do_push;
  logic          do_pop;

  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign do_pop  = pop & (count_q != '0) & ~clear;
  assign do_push = push & ~clear & ((count_q != CW'(DEPTH)) | do_pop);

  always_comb begin
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q + CW'(do_push) - CW'(do_pop);
    last_d   = last_q;
    if (clear) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = push_data;
        wr_ptr_d        = ptr_next(wr_ptr_q);
      end
      if (do_pop) begin
        last_d   = mem_q[rd_ptr_q];
        rd_ptr_d = ptr_next(rd_ptr_q);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst_) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      last_q   <= IDLE_HEAD;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      last_q   <= last_d;
    end
  end

  // Storage needs no reset: it is only visible while count is non-zero.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign count = count_q;
  assign head  = (count_q != '0) ? mem_q[rd_ptr_q] : last_q;

  a_no_overflow: assert property (@(posedge clk) disable iff (rst_)
    (push && !clear && count_q == CW'(DEPTH)) |-> do_pop);

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: sequential PC generation, credit-limited imem requests,
// in-order response buffering and branch flush of buffered and in-flight fetches.
module if_fetch_unit
  import rv32_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst_,
  input  logic        stall,
  input  logic        branch,
  input  logic [31:0] branch_target,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic [31:0] pc,
  output logic [31:0] instr,
  output logic        valid
);

  localparam int CW = $clog2(DEPTH + 1);

  fetch_state_e  state_q;
  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   resp_pc_q, resp_pc_d;
  logic [CW-1:0] outst_q, outst_d;
  logic [CW-1:0] drop_q, drop_d;

  logic [CW-1:0] fifo_count;
  logic [63:0]   fifo_head_raw;
  fetch_entry_t  fifo_head;
  fetch_entry_t  push_entry;
  logic [31:0]   target_aligned;
  logic          running;
  logic          credit_ok;
  logic          issue;
  logic          rsp_fire;
  logic          dropping;
  logic          push;
  logic          pop;
  logic          unused_target_lsbs;

  assign target_aligned     = {branch_target[31:2], 2'b00};
  assign unused_target_lsbs = ^branch_target[1:0];

  assign running   = (state_q == ST_RUN);
  // Credit covers both in-flight and buffered fetches, so the FIFO can never overflow.
  assign credit_ok = ({1'b0, outst_q} + {1'b0, fifo_count}) < (CW + 1)'(DEPTH);
  assign imem_req_valid = running & ~branch & credit_ok;
  assign imem_addr      = fetch_pc_q;
  assign issue          = imem_req_valid & imem_req_ready;

  // A response with nothing outstanding is a protocol error and is ignored.
  assign rsp_fire = running & imem_rsp_valid & (outst_q != '0);
  assign dropping = (drop_q != '0);
  assign push     = rsp_fire & ~dropping & ~branch;
  assign valid    = (fifo_count != '0);
  assign pop      = valid & ~stall & ~branch;

  assign push_entry = '{pc: resp_pc_q, instr: imem_rsp_data};

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    resp_pc_d  = resp_pc_q;
    outst_d    = outst_q + CW'(issue) - CW'(rsp_fire);
    drop_d     = drop_q;
    if (branch) begin
      fetch_pc_d = target_aligned;
      resp_pc_d  = target_aligned;
      drop_d     = outst_q - CW'(rsp_fire);
    end else begin
      if (issue) fetch_pc_d = fetch_pc_q + PC_INCR;
      if (push)  resp_pc_d  = resp_pc_q + PC_INCR;
      if (rsp_fire && dropping) drop_d = drop_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst_) begin
      state_q <= ST_BOOT;
    end else begin
      case (state_q)
        ST_BOOT: state_q <= ST_RUN;
        ST_RUN:  state_q <= ST_RUN;
        default: state_q <= ST_BOOT;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst_) begin
      fetch_pc_q <= RESET_PC;
      resp_pc_q  <= RESET_PC;
      outst_q    <= '0;
      drop_q     <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      resp_pc_q  <= resp_pc_d;
      outst_q    <= outst_d;
      drop_q     <= drop_d;
    end
  end

  fetch_fifo #(
    .DEPTH     (DEPTH),
    .W         (64),
    .IDLE_HEAD ({RESET_PC, NOP_INSTR})
  ) u_fifo (
    .clk       (clk),
    .rst_      (rst_),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .clear     (branch),
    .count     (fifo_count),
    .head      (fifo_head_raw)
  );

  assign fifo_head = fetch_entry_t'(fifo_head_raw);
  assign pc        = fifo_head.pc;
  assign instr     = fifo_head.instr;

  a_rsp_has_outst: assert property (@(posedge clk) disable iff (rst_)
    (running && imem_rsp_valid) |-> (outst_q != '0));

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: behavioural imem with variable latency, scoreboard of
// expected {pc, instr} pairs, directed reset/stall/branch scenarios and random traffic.
module tb_if_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP      = 32'h0000_0013;
  localparam int          DEPTH    = 2;

  logic        clk = 1'b0;
  logic        rst_ = 1'b1;
  logic        stall = 1'b0;
  logic        branch = 1'b0;
  logic [31:0] branch_target = 32'h0;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b0;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = 32'h0;
  logic [31:0] pc;
  logic [31:0] instr;
  logic        valid;

  if_fetch_unit #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
    .clk            (clk),
    .rst_           (rst_),
    .stall          (stall),
    .branch         (branch),
    .branch_target  (branch_target),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_addr      (imem_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .pc             (pc),
    .instr          (instr),
    .valid          (valid)
  );

  // Clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  // Checking
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %h expected %h", tag, got, exp);
    else n_pass++;
  endtask

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return {a[15:0] ^ 16'hC0DE, a[31:16] ^ 16'h1234};
  endfunction

  // Memory model and scoreboard
  typedef struct {
    logic [31:0] addr;
    int          due;
  } mem_req_t;

  mem_req_t    pend_q[$];
  logic [63:0] exp_q[$];
  int          occ = 0;
  int          drop_m = 0;
  int          cyc = 0;
  int          n_pop = 0;
  logic [31:0] next_fetch = RESET_PC;
  bit          rand_ready = 0;
  int          lat_min = 1;
  int          lat_max = 1;

  always begin
    bit fire;
    bit pop_m;
    @(negedge clk);
    imem_req_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    if (pend_q.size() != 0 && pend_q[0].due <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = instr_of(pend_q[0].addr);
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = 32'h0;
    end
    #1;
    if (rst_) begin
      pend_q.delete();
      exp_q.delete();
      occ        = 0;
      drop_m     = 0;
      next_fetch = RESET_PC;
    end else begin
      fire  = imem_req_valid && imem_req_ready;
      pop_m = (occ != 0) && !stall && !branch;
      check_eq("valid", valid, occ != 0);
      if (occ != 0 && exp_q.size() != 0) check_eq("head", {pc, instr}, exp_q[0]);
      if (fire) begin
        check_eq("req_addr", imem_addr, next_fetch);
        check_eq("credit", (pend_q.size() + occ) < DEPTH, 1);
      end
      if (branch) check_eq("req_in_branch", imem_req_valid, 0);
      if (imem_rsp_valid) void'(pend_q.pop_front());
      if (branch) begin
        exp_q.delete();
        occ        = 0;
        drop_m     = pend_q.size();
        next_fetch = {branch_target[31:2], 2'b00};
      end else begin
        if (imem_rsp_valid) begin
          if (drop_m > 0) drop_m--;
          else occ++;
        end
        if (pop_m) begin
          if (exp_q.size() != 0) void'(exp_q.pop_front());
          occ--;
          n_pop++;
        end
        if (fire) begin
          pend_q.push_back('{addr: imem_addr, due: cyc + $urandom_range(lat_max, lat_min)});
          exp_q.push_back({next_fetch, instr_of(next_fetch)});
          next_fetch = next_fetch + 32'd4;
        end
      end
    end
    cyc++;
  end

  // Driver tasks
  task automatic release_reset();
    int n;
    @(negedge clk);
    rst_   = 1'b0;
    stall  = 1'b0;
    branch = 1'b0;
    #2;
    check_eq("rst_valid", valid, 0);
    check_eq("rst_pc", pc, RESET_PC);
    check_eq("rst_instr", instr, NOP);
    check_eq("boot_no_req", imem_req_valid, 0);
    n = 0;
    while (n < 20) begin
      @(negedge clk);
      #2;
      n++;
      if (n == 1) begin
        check_eq("first_req", imem_req_valid, 1);
        check_eq("first_addr", imem_addr, RESET_PC);
      end
      if (valid) break;
    end
    check_eq("first_valid_cyc", n, 3);
  endtask

  task automatic wait_occ(input int target, input string tag);
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (occ == target) return;
    end
    check_eq({tag, "_timeout"}, 0, 1);
  endtask

  task automatic wait_pend(input int target, input string tag);
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (pend_q.size() == target) return;
    end
    check_eq({tag, "_timeout"}, 0, 1);
  endtask

  task automatic wait_valid_pc(input logic [31:0] exp_pc, input string tag);
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      #2;
      if (valid) begin
        check_eq({tag, "_pc"}, pc, exp_pc);
        check_eq({tag, "_instr"}, instr, instr_of(exp_pc));
        return;
      end
    end
    check_eq({tag, "_timeout"}, 0, 1);
  endtask

  task automatic pulse_branch(input logic [31:0] target);
    branch        = 1'b1;
    branch_target = target;
    #2;
    check_eq("br_cycle_no_req", imem_req_valid, 0);
    @(negedge clk);
    branch = 1'b0;
  endtask

  // Stimulus
  initial begin
    int start_pop;
    int guard;
    repeat (2) @(negedge clk);
    release_reset();

    // Streaming, then a stall held over several cycles
    repeat (20) @(negedge clk);
    stall = 1'b1;
    repeat (4) @(negedge clk);
    #2;
    check_eq("stall_no_req", imem_req_valid, 0);
    check_eq("stall_valid", valid, 1);
    @(negedge clk);
    stall = 1'b0;
    repeat (10) @(negedge clk);

    // Redirect with two fetches in flight at latency 2
    lat_min = 2;
    lat_max = 2;
    wait_pend(2, "br_pend");
    pulse_branch(32'h0000_0102);
    wait_valid_pc(32'h0000_0100, "br_first");
    repeat (10) @(negedge clk);

    // Redirect together with stall while the FIFO is full
    lat_min = 1;
    lat_max = 1;
    stall   = 1'b1;
    wait_occ(2, "bs_full");
    pulse_branch(32'h0000_0200);
    stall = 1'b0;
    #2;
    check_eq("bs_flush_valid", valid, 0);
    wait_valid_pc(32'h0000_0200, "bs_first");

    // Random back-pressure, latency and stall
    rand_ready = 1;
    lat_min    = 1;
    lat_max    = 3;
    start_pop  = n_pop;
    guard      = 0;
    while ((n_pop - start_pop) < 200 && guard < 4000) begin
      @(negedge clk);
      stall = ($urandom_range(0, 3) == 0);
      guard++;
    end
    check_eq("rand_done", (n_pop - start_pop) >= 200, 1);
    stall      = 1'b0;
    rand_ready = 0;
    lat_min    = 1;
    lat_max    = 1;
    repeat (5) @(negedge clk);

    // Reset pulsed with the FIFO holding two entries
    stall = 1'b1;
    wait_occ(2, "rst_full");
    rst_ = 1'b1;
    release_reset();
    repeat (15) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
